// File: rtl/vsc8541_mdio_responder.sv
// Clause 22 MDIO/SMI responder: oversamples MDC/MDIO on clk, decodes frames, strobes writes, serves reads.
// Optional MDIO_PREAMBLE_SUPPRESS_EN: accept ST without a full preamble (IEEE preamble suppression).
module vsc8541_mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_mdc,
    inout  wire         io_mdio,
    output logic [4:0]  o_reg_addr,
    output logic        o_wr_stb,
    output logic [15:0] o_wr_data,
    output logic        o_rd_stb,
    input  logic [15:0] i_rd_data,
    output logic        o_busy,
    output logic        o_frame_err
);

    localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int unsigned CNT_W = 5;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
    } state_e;

    logic [1:0]       mdc_sync_q, mdio_sync_q;
    logic             mdc_prev_q;
    logic             mdc_rise, mdc_fall, mdio_bit;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             is_read_q, is_read_d;
    logic             match_q, match_d;
    logic [14:0]      shift_q, shift_d;
    logic [15:0]      tx_q, tx_d;
    logic             oe_q, oe_d;
    logic             out_q, out_d;
    logic [4:0]       reg_addr_q, reg_addr_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             wr_stb_q, wr_stb_d;
    logic             rd_stb_q, rd_stb_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;

    // Two-flop synchronizers plus edge detector on the synchronized MDC
    always_ff @(posedge clk) begin
        mdc_sync_q  <= {mdc_sync_q[0], i_mdc};
        mdio_sync_q <= {mdio_sync_q[0], io_mdio};
        mdc_prev_q  <= mdc_sync_q[1];
    end

    assign mdc_rise = mdc_sync_q[1] & ~mdc_prev_q;
    assign mdc_fall = ~mdc_sync_q[1] & mdc_prev_q;
    assign mdio_bit = mdio_sync_q[1];

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            shift_q     <= '0;
            tx_q        <= '0;
            oe_q        <= 1'b0;
            out_q       <= 1'b0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        oe_d        = oe_q;
        out_d       = out_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        frame_err_d = 1'b0;

        // Register-bus read data is captured the clk after the read strobe
        if (rd_stb_q) begin
            tx_d = i_rd_data;
        end

        if (mdc_rise && (state_q != S_IDLE)) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = {shift_q[13:0], mdio_bit};
        end

        case (state_q)
            S_IDLE: begin
                if (mdc_rise) begin
                    if (mdio_bit) begin
                        if (pre_cnt_q < PRE_MAX) begin
                            pre_cnt_d = pre_cnt_q + PRE_W'(1);
                        end
                    end else begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                        state_d = S_ST;
`else
                        if (pre_cnt_q >= PRE_MAX) begin
                            state_d = S_ST;
                        end
`endif
                        pre_cnt_d = '0;
                    end
                end
            end
            S_ST: begin
                if (mdc_rise) begin
                    if (mdio_bit) begin
                        state_d = S_OP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_OP: begin
                if (mdc_rise && (bit_cnt_q == 5'd1)) begin
                    case ({shift_q[0], mdio_bit})
                        2'b10: begin
                            is_read_d = 1'b1;
                            state_d   = S_PHYAD;
                        end
                        2'b01: begin
                            is_read_d = 1'b0;
                            state_d   = S_PHYAD;
                        end
                        default: begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    endcase
                end
            end
            S_PHYAD: begin
                if (mdc_rise && (bit_cnt_q == 5'd4)) begin
                    match_d = ({shift_q[3:0], mdio_bit} == PHY_ADDR);
                    state_d = S_REGAD;
                end
            end
            S_REGAD: begin
                if (mdc_rise && (bit_cnt_q == 5'd4)) begin
                    if (match_q) begin
                        reg_addr_d = {shift_q[3:0], mdio_bit};
                        rd_stb_d   = is_read_q;
                    end
                    state_d = S_TA;
                end
            end
            S_TA: begin
                // Drive the turnaround 0 on the falling edge that opens TA bit 2
                if (mdc_fall && (bit_cnt_q == 5'd1) && is_read_q && match_q) begin
                    oe_d  = 1'b1;
                    out_d = 1'b0;
                end
                if (mdc_rise && (bit_cnt_q == 5'd1)) begin
                    state_d = is_read_q ? S_RDATA : S_WDATA;
                end
            end
            S_WDATA: begin
                if (mdc_rise && (bit_cnt_q == 5'd15)) begin
                    if (match_q) begin
                        wr_data_d = {shift_q, mdio_bit};
                        wr_stb_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (match_q) begin
                    if (mdc_fall) begin
                        if (bit_cnt_q == 5'd16) begin
                            oe_d    = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            out_d = tx_q[15];
                            tx_d  = {tx_q[14:0], 1'b0};
                        end
                    end
                end else if (mdc_rise && (bit_cnt_q == 5'd15)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign io_mdio     = oe_q ? out_q : 1'bz;
    assign o_reg_addr  = reg_addr_q;
    assign o_wr_stb    = wr_stb_q;
    assign o_wr_data   = wr_data_q;
    assign o_rd_stb    = rd_stb_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: doc/vsc8541_mdio_responder.md
Name: vsc8541_mdio_responder

Overview:
MDIO/SMI management responder (Clause 22 slave side) for the VSC8541 management interface.
- Oversamples an externally driven MDC/MDIO pair on the system clock and decodes preamble, ST, OP, PHYAD, REGAD and TA.
- Write frames: captures 16 data bits and issues a register-write strobe.
- Read frames: fetches register data over a simple register bus and drives it on io_mdio.
- Used as a PHY model in benches and as the slave end of FPGA-to-FPGA management links.

Parameters:
- PHY_ADDR, 5'd0: PHYAD value this responder answers to.
- PREAMBLE_LEN, 32: minimum consecutive sampled 1s required before a 0 is accepted as the ST first bit.

Ports:
- clk  input  1  system clock; must be ≥8× MDC frequency.
- i_reset  input  1  synchronous, active-high reset.
- i_mdc  input  1  management clock from the master; asynchronous to clk.
- io_mdio  inout  1  management data; driven only during read TA bit 2 and read data, otherwise 'z.
- o_reg_addr  output  5  REGAD of the current frame; valid from the o_rd_stb or o_wr_stb cycle until the next frame's REGAD completes.
- o_wr_stb  output  1  one-clk pulse: write frame addressed to PHY_ADDR completed.
- o_wr_data  output  16  write data; valid with o_wr_stb and held afterwards.
- o_rd_stb  output  1  one-clk pulse: read frame addressed to PHY_ADDR needs data.
- i_rd_data  input  16  read data; sampled exactly one clk after o_rd_stb.
- o_busy  output  1  high while in any state other than IDLE.
- o_frame_err  output  1  one-clk pulse on a bad ST or an illegal OP.

Behaviour:
- Input conditioning: i_mdc and io_mdio each pass through a 2-flop synchronizer. A prev_mdc register then gives rise and fall detection on the synchronized MDC.
- All bit sampling uses the synchronized MDIO on detected rising edges.
- All drive changes occur on detected falling edges, 3 clk after the pin edge.
- Reset values: io_mdio released ('z); o_wr_stb, o_rd_stb, o_frame_err, o_busy = 0; o_reg_addr = 0; o_wr_data = 0; preamble count = 0; state = IDLE.
- Reset mid-frame: the same values are restored on the next clk and the bus is released immediately.
- FSM states: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA. A bit counter is cleared on every state change.
- IDLE:
  - Each sampled 1 increments the preamble counter, saturating at PREAMBLE_LEN.
  - A sampled 0 with count ≥ PREAMBLE_LEN goes to ST.
  - A sampled 0 with count below PREAMBLE_LEN clears the count and stays in IDLE.
- ST: next sampled bit must be 1. Then go to OP; otherwise pulse o_frame_err and go to IDLE.
- OP: 2 bits, MSB first. 10 = read, 01 = write. 00 or 11 pulse o_frame_err and go to IDLE.
- PHYAD: 5 bits MSB first. Set match = (PHYAD == PHY_ADDR).
- REGAD: 5 bits MSB first.
  - o_reg_addr updates on the 5th bit only if match.
  - Read with match: o_rd_stb pulses in that same clk; i_rd_data is loaded into the tx shift register on the next clk.
- TA: 2 sampled bits, values ignored.
  - Read with match: stay 'z for TA bit 1; on the falling edge starting TA bit 2, drive 0.
  - Then go to RDATA (read) or WDATA (write).
- RDATA, match:
  - On each of the next 16 falling edges, drive shift[15], then shift left.
  - On the falling edge after D0's rising edge, release io_mdio and go to IDLE.
- RDATA, no match: count 16 rising edges without driving, then go to IDLE.
- WDATA:
  - Shift in 16 bits MSB first.
  - On the 16th rising edge, if match: update o_wr_data and pulse o_wr_stb for one clk.
  - Go to IDLE.
- Preamble on return to IDLE:
  - The preamble counter restarts at 0, so each frame needs its own preamble.
  - Idle 1s after a frame count toward the next preamble.
- MDC stopping mid-frame: the FSM holds its state indefinitely. There is no timeout; only i_reset recovers.
- The responder never drives io_mdio for a non-matching PHYAD or for write frames.

Optional Feature:
MDIO_PREAMBLE_SUPPRESS_EN
- Defined: a 0 sampled in IDLE is accepted as ST bit 1 regardless of the preamble count. This gives IEEE preamble suppression; PREAMBLE_LEN is used only to set the counter width.
- Undefined: the PREAMBLE_LEN rule applies as described above.

Test Plan:
- Reset, then idle MDC with io_mdio pulled high → io_mdio 'z, all strobes 0, o_busy 0.
- Write frame, PHY_ADDR=3: 32×1, ST=01, OP=01, PHYAD=3, REGAD=0x1F, TA=10, data=0xA5C3 → one o_wr_stb, o_reg_addr=0x1F, o_wr_data=0xA5C3, io_mdio never driven.
- Read frame, PHYAD=3, REGAD=0x02, i_rd_data=0x0007 → o_rd_stb once.
  - io_mdio 'z during TA1, 0 during TA2.
  - Master samples 0x0007 on rising edges; bus released after D0.
- Read frame to PHYAD=4 (PHY_ADDR=3) → no o_rd_stb, io_mdio 'z for the whole frame, FSM back in IDLE; a following valid write is accepted.
- Short preamble (16×1, then a valid write) → no o_wr_stb without the macro; with MDIO_PREAMBLE_SUPPRESS_EN, o_wr_stb fires.
- Fault cases:
  - OP=11 → o_frame_err pulse, then IDLE.
  - i_reset asserted during RDATA bit 8 → io_mdio 'z on the next clk; the next full frame is decoded correctly.
